// File: rtl/reg_stream_reader.sv
// First-word-fall-through buffer that captures one-cycle strobes from an upstream
// register, dropping (and counting) strobes that arrive while it is full.
module reg_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         a_reset_n,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [7:0]                   drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    logic       overflow_q, overflow_d;
    logic [7:0] drop_count_q, drop_count_d;

    logic full, push, pop, drop;

    // DEPTH is a power of two, so pointer wrap-around is plain overflow of PTR_W bits.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        full         = (count_q == cnt_t'(DEPTH));
        pop          = (count_q != '0) && out_ready;
        push         = in_valid && (!full || pop);
        drop         = in_valid && !push;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

        if (push && !pop)      count_d = count_q + cnt_t'(1);
        else if (pop && !push) count_d = count_q - cnt_t'(1);

        // A drop in the same cycle as a clear restarts the tally at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)             drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: storage is reset too, so out_data reads zero during and after reset.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_reg_stream_reader.sv
// Directed bench for reg_stream_reader: capture, ordering, overflow, clear, saturation
// and asynchronous reset, with hand-computed expected values.
module tb_reg_stream_reader;

    logic       clk = 1'b0;
    logic       a_reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       overflow;
    logic       clear_overflow;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    reg_stream_reader #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk            (clk),
        .a_reset_n      (a_reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        a_reset_n      = 1'b0;
        in_valid       = 1'b0;
        in_data        = 8'h00;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
        a_reset_n = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL post_rst: got valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    // Called straight after reset release: the first edge must already capture.
    task automatic test_single_capture();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got out_valid=%b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", out_data); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL single_drain: got valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_ordering();
        logic [7:0] exp_q [3] = '{8'h01, 8'h02, 8'h03};
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL order_count: got %0d want 3", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin n_err++; $display("FAIL order_word%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp_q[i]); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL order_empty: got valid=%b count=%0d want 0/0", out_valid, count); end
        // out_ready held while empty must not disturb the pointers.
        tick();
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_ready_count: got %0d want 0", count); end
        push_word(8'h5A);
        n_cmp++; if (out_data !== 8'h5A || count !== 3'd1) begin n_err++; $display("FAIL empty_ready_ptr: got data=%h count=%0d want 5a/1", out_data, count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL ovf_drop_count: got %0d want 1", drop_count); end
        tick();
        tick();
        n_cmp++; if (out_data !== 8'h10) begin n_err++; $display("FAIL stall_stable: got %h want 10", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin n_err++; $display("FAIL ovf_word%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL ovf_clear: got ovf=%b drops=%0d want 0/0", overflow, drop_count); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [4] = '{8'h21, 8'h22, 8'h23, 8'h77};
        for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i));
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fpp_count: got %0d want 4", count); end
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL fpp_no_ovf: got ovf=%b drops=%0d want 0/0", overflow, drop_count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin n_err++; $display("FAIL fpp_word%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fpp_empty: got %0d want 0", count); end
    endtask

    task automatic test_clear_vs_drop();
        for (int i = 0; i < 7; i++) push_word(8'h30 + 8'(i));
        n_cmp++; if (drop_count !== 8'd3 || count !== 3'd4) begin n_err++; $display("FAIL cvd_setup: got drops=%0d count=%0d want 3/4", drop_count, count); end
        in_valid       = 1'b1;
        in_data        = 8'hEE;
        clear_overflow = 1'b1;
        tick();
        in_valid       = 1'b0;
        clear_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin n_err++; $display("FAIL cvd_result: got ovf=%b drops=%0d want 1/1", overflow, drop_count); end
        n_cmp++; if (out_data !== 8'h30 || count !== 3'd4) begin n_err++; $display("FAIL cvd_contents: got data=%h count=%0d want 30/4", out_data, count); end
    endtask

    // Buffer is still full with drop_count=1; 260 more drops must stop at 255.
    task automatic test_saturation();
        in_valid = 1'b1;
        in_data  = 8'hCC;
        for (int i = 0; i < 254; i++) tick();
        n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_reach: got %0d want 255", drop_count); end
        for (int i = 0; i < 6; i++) tick();
        in_valid = 1'b0;
        n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
    endtask

    task automatic test_reset_mid();
        a_reset_n = 1'b0;
        #1;
        a_reset_n = 1'b1;
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_setup: got %0d want 3", count); end
        #2;
        a_reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin n_err++; $display("FAIL mid_async: got valid=%b count=%0d data=%h want 0/0/00", out_valid, count, out_data); end
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL mid_flags: got ovf=%b drops=%0d want 0/0", overflow, drop_count); end
        tick();
        a_reset_n = 1'b1;
        push_word(8'h99);
        n_cmp++; if (out_data !== 8'h99 || count !== 3'd1) begin n_err++; $display("FAIL mid_first_push: got data=%h count=%0d want 99/1", out_data, count); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_clear_vs_drop();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
